ffo_48: RTL and testbench
=========================

// Module: ffo_48
// PURPOSE
//  Find-first-one over a 48-bit vector: returns the index of the highest-numbered set bit.
//  Used by the register-rename allocator to pick free physical registers from the avail mask.
//  The allocator cascades three instances on a successively masked avail vector.
//  Combinational result for same-cycle use, plus a registered copy for pipelined consumers.
// PARAMETERS
//  NONE_VAL  6'd63  index reported when no input bit is set (outside the legal range 0..47)
// PORTS
//  clk      in   1   clock; all registers update on the rising edge
//  rst      in   1   asynchronous, active-high reset
//  ce       in   1   clock enable for the registered outputs
//  i        in   48  input vector; bit n set = candidate n
//  o        out  6   combinational index of the highest set bit of i, else NONE_VAL
//  found    out  1   combinational; 1 iff |i
//  o_q      out  6   o registered when ce=1
//  found_q  out  1   found registered when ce=1
//  oh_q     out  48  registered one-hot of o_q (see CONFIGURATION)
// BEHAVIOUR
//  - o = max{n : i[n]==1}. When i==0: o=NONE_VAL, found=0.
//  - o and found are purely combinational: zero latency, no dependence on clk, rst or ce.
//  - Structure: 8 groups of 6 bits. Each group gives a 3-bit local index and a group-any flag.
//  - An 8-way priority on the group flags selects the highest non-empty group g.
//  - o = g*6 + local index of group g. Arithmetic is 6 bits wide; the maximum is 47, so no overflow.
//  - Registered path, on posedge clk with ce=1: o_q<=o, found_q<=found, oh_q<=onehot.
//  - With ce=0, the registered outputs hold their values.
//  - Reset (asynchronous, active-high): o_q=NONE_VAL, found_q=0, oh_q=0.
//    Reset applies immediately, including mid-operation, and overrides ce.
//    The first capture occurs on the first rising edge after rst deasserts, if ce=1.
//  - Boundaries:
//    - i==48'h0 gives NONE_VAL.
//    - i==48'hFFFF_FFFF_FFFF gives 47.
//    - A single bit set gives its own index.
//    - Bits in multiple groups: the higher group always wins.
//  - X/Z on i is not required to be handled. No state other than the output registers.
// CONFIGURATION
//  FFO48_ONEHOT_EN
//  - Defined: oh_q is registered as 48'd1<<o when found=1, else 0.
//  - Undefined: oh_q is tied to 48'd0 and no one-hot logic is built.
//  - o, o_q, found and found_q are identical in both builds.
// TESTING
//  - i=48'h0 -> o=63, found=0; after a clk edge with ce=1: o_q=63, found_q=0.
//  - Walk single bit n=0..47 -> o=n, found=1; o_q=n one cycle later;
//    with FFO48_ONEHOT_EN: oh_q=1<<n.
//  - i=48'h8000_0000_0001 -> o=47.
//  - i=48'h0000_0000_0FC0 -> o=11.
//  - i=48'h0000_0003_0000 -> o=17.
//  - Random i with ce toggling: o_q updates only on edges with ce=1 and otherwise holds;
//    compare against a reference model.
//  - Assert rst between clock edges after o_q=5 -> o_q=63, found_q=0, oh_q=0 immediately;
//    release rst with i=48'h10 -> o_q=4 on the next edge.

Source files
------------

// File: rtl/ffo_48_if.sv
// ffo_48_if: ports of the 48-bit find-first-one (inputs and combinational/registered results).
interface ffo_48_if;
   logic        ce;
   logic [47:0] i;
   logic [5:0]  o;
   logic        found;
   logic [5:0]  o_q;
   logic        found_q;
   logic [47:0] oh_q;
   modport master (output ce, i, input o, found, o_q, found_q, oh_q);
   modport slave  (input ce, i, output o, found, o_q, found_q, oh_q);
endinterface

// File: rtl/ffo_48.sv
// ffo_48: index of the highest set bit of a 48-bit vector, combinational plus registered copy.
// FFO48_ONEHOT_EN builds the registered one-hot output; otherwise oh_q is tied to zero.
module ffo_48 #(
   parameter logic [5:0] NONE_VAL = 6'd63
) (
   input logic    clk,
   input logic    rst,
   ffo_48_if.slave bus
);
   function automatic logic [2:0] ffo6(input logic [5:0] v);
      ffo6 = 3'd0;
      for (int k = 0; k < 6; k++) if (v[k]) ffo6 = 3'(k);
   endfunction
   logic [2:0] w_loc [8];
   logic [7:0] w_any;
   logic [2:0] w_g;
   logic [5:0] w_o;
   logic       w_found;
   logic [5:0] r_o_q;
   logic       r_found_q;
   for (genvar g = 0; g < 8; g++) begin : grp
      assign w_loc[g] = ffo6(bus.i[g*6 +: 6]);
      assign w_any[g] = |bus.i[g*6 +: 6];
   end
   // Highest non-empty group wins.
   always_comb begin
      w_g = 3'd0;
      for (int k = 0; k < 8; k++) if (w_any[k]) w_g = 3'(k);
   end
   assign w_found = |w_any;
   assign w_o = w_found ? {3'b0, w_g} * 6'd6 + {3'b0, w_loc[w_g]} : NONE_VAL;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_o_q     <= NONE_VAL;
         r_found_q <= 1'b0;
      end else if (bus.ce) begin
         r_o_q     <= w_o;
         r_found_q <= w_found;
      end
`ifdef FFO48_ONEHOT_EN
   logic [47:0] r_oh_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_oh_q <= '0;
      else if (bus.ce) r_oh_q <= w_found ? 48'd1 << w_o : '0;
   assign bus.oh_q = r_oh_q;
`else
   assign bus.oh_q = '0;
`endif
   assign bus.o       = w_o;
   assign bus.found   = w_found;
   assign bus.o_q     = r_o_q;
   assign bus.found_q = r_found_q;
endmodule

// File: tb/tb_ffo_48.sv
// tb_ffo_48: random and directed checks of ffo_48 against a behavioural highest-set-bit model.
module tb_ffo_48;
   logic clk = 1'b0;
   logic rst = 1'b0;
   ffo_48_if bus ();
   ffo_48 dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_bad = 0;
   logic [5:0] m_q;
   logic       m_f;
   function automatic logic [5:0] ref_ffo(input logic [47:0] v);
      for (int n = 47; n >= 0; n--) if (v[n]) return 6'(n);
      return 6'd63;
   endfunction
   function automatic logic [47:0] exp_oh();
`ifdef FFO48_ONEHOT_EN
      return m_f ? (48'd1 << m_q) : 48'd0;
`else
      return 48'd0;
`endif
   endfunction
   task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic compare_all();
      check("o", 48'(bus.o), 48'(ref_ffo(bus.i)));
      check("found", 48'(bus.found), 48'(bus.i != 48'd0));
      check("o_q", 48'(bus.o_q), 48'(m_q));
      check("found_q", 48'(bus.found_q), 48'(m_f));
      check("oh_q", bus.oh_q, exp_oh());
   endtask
   task automatic model_reset();
      m_q = 6'd63;
      m_f = 1'b0;
   endtask
   task automatic step(input logic [47:0] vi, input logic vce);
      bus.i  = vi;
      bus.ce = vce;
      @(posedge clk);
      if (vce) begin
         m_q = ref_ffo(vi);
         m_f = vi != 48'd0;
      end
      @(negedge clk);
      compare_all();
   endtask
   initial begin
      logic [47:0] v;
      bus.ce = 1'b0;
      bus.i  = 48'd0;
      model_reset();
      #1 rst = 1'b1;
      #1;
      check("rst_o_q", 48'(bus.o_q), 48'd63);
      check("rst_found_q", 48'(bus.found_q), 48'd0);
      check("rst_oh_q", bus.oh_q, 48'd0);
      @(negedge clk);
      rst = 1'b0;
      step(48'd0, 1'b1);
      check("zero_o", 48'(bus.o), 48'd63);
      check("zero_found", 48'(bus.found), 48'd0);
      check("zero_o_q", 48'(bus.o_q), 48'd63);
      for (int n = 0; n < 48; n++) begin
         step(48'd1 << n, 1'b1);
         check("walk_o_q", 48'(bus.o_q), 48'(n));
      end
      step(48'h8000_0000_0001, 1'b1);
      check("ends_o", 48'(bus.o), 48'd47);
      step(48'h0000_0000_0FC0, 1'b1);
      check("grp1_o", 48'(bus.o), 48'd11);
      step(48'h0000_0003_0000, 1'b1);
      check("b17_o", 48'(bus.o), 48'd17);
      step(48'hFFFF_FFFF_FFFF, 1'b1);
      check("all_o", 48'(bus.o), 48'd47);
      for (int k = 0; k < 400; k++) begin
         v = {$urandom, $urandom};
         v = v >> $urandom_range(0, 47);
         if ($urandom_range(0, 9) == 0) v = 48'd0;
         step(v, 1'($urandom_range(0, 1)));
      end
      step(48'h20, 1'b1);
      check("pre_rst_o_q", 48'(bus.o_q), 48'd5);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("async_o_q", 48'(bus.o_q), 48'd63);
      check("async_found_q", 48'(bus.found_q), 48'd0);
      check("async_oh_q", bus.oh_q, 48'd0);
      bus.i  = 48'h10;
      bus.ce = 1'b1;
      @(negedge clk);
      compare_all();
      rst = 1'b0;
      step(48'h10, 1'b1);
      check("post_rst_o_q", 48'(bus.o_q), 48'd4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
